// File: rtl/lcd_write_arb_pkg.sv
// Shared definitions for the LCD writer arbiter: word layout, FSM encoding and the
// default wr_done watchdog limit.
package lcd_write_arb_pkg;

  localparam int          DW          = 9;
  localparam int          DC_BIT      = 8;
  localparam int          MAXREQ      = 8;
  localparam logic [15:0] TIMEOUT_DEF = 16'd4095;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_t;

  function automatic logic [2:0] oh2idx(input logic [MAXREQ-1:0] oh);
    oh2idx = 3'd0;
    for (int i = 0; i < MAXREQ; i++) begin
      if (oh[i]) oh2idx = i[2:0];
    end
  endfunction

endpackage

// File: rtl/lcd_write_arb_if.sv
// Requester and SPI-writer signals of the LCD write arbiter. The master modport is
// the arbiter; the slave modport is the requesters plus the byte writer.
interface lcd_write_arb_if #(
  parameter int NREQ = 3,
  parameter int DW   = lcd_write_arb_pkg::DW
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic               ack_err;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      lcd_data;
  logic               lcd_en_write;
  logic               lcd_wr_done;

  modport master (
    input  req, req_last, req_data, lcd_wr_done,
    output ack, ack_err, gnt, lcd_data, lcd_en_write
  );

  modport slave (
    output req, req_last, req_data, lcd_wr_done,
    input  ack, ack_err, gnt, lcd_data, lcd_en_write
  );
endinterface

// File: rtl/lcd_write_arb_rr_pick.sv
// Rotating-priority pick: one-hot of the first set request at or after ptr_i, wrapping.
// ptr_i must be below NREQ.
module lcd_write_arb_rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] first;

  // Rotate so ptr_i lands at bit 0, isolate the lowest set bit, rotate back.
  assign rot   = NREQ'({req_i, req_i} >> ptr_i);
  assign first = rot & (~rot + ONE);
  assign gnt_o = NREQ'(({first, first} << ptr_i) >> NREQ);

endmodule

// File: rtl/lcd_write_arb.sv
// Round-robin arbiter sharing one LCD SPI byte writer among NREQ requesters, with
// transaction locking, init gating and a wr_done watchdog.
module lcd_write_arb
  import lcd_write_arb_pkg::*;
#(
  parameter int          NREQ    = 3,
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init_done_i,
  output logic            timeout_err_o,
  lcd_write_arb_if.master bus
);

  localparam logic [NREQ-1:0] INIT_ONLY = NREQ'(1);

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic            ack_err_q;
  logic            en_q;
  logic            last_q;
  logic            lock_q;
  logic            terr_q;
  logic [DW-1:0]   data_q;
  logic [2:0]      rr_ptr_q;
  logic [15:0]     timer_q;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] issue_oh;
  logic            hold_ok;
  logic            issue_go;
  logic [DW-1:0]   sel_data;
  logic            sel_last;
  logic [2:0]      own_idx;
  logic [2:0]      ptr_nxt;
  logic            tmo_hit;
  logic [15:0]     timer_inc;

  assign elig = init_done_i ? '1 : INIT_ONLY;
  assign cand = bus.req & elig;

  lcd_write_arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (cand),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick)
  );

  // A locked owner skips arbitration; an owner that lost eligibility falls back to it.
  assign hold_ok  = (state_q == S_HOLD) && |(gnt_q & elig);
  assign issue_oh = hold_ok ? (gnt_q & bus.req) : pick;
  assign issue_go = ((state_q == S_IDLE) || (state_q == S_HOLD)) && |issue_oh;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (issue_oh[i]) begin
        sel_data = bus.req_data[i*DW +: DW];
        sel_last = bus.req_last[i];
      end
    end
  end

  assign own_idx   = oh2idx(MAXREQ'(gnt_q));
  assign ptr_nxt   = (own_idx == 3'(NREQ - 1)) ? 3'd0 : own_idx + 3'd1;
  assign tmo_hit   = ({1'b0, timer_q} + 17'd1) >= {1'b0, TIMEOUT};
  assign timer_inc = (&timer_q) ? timer_q : timer_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      ack_err_q <= 1'b0;
      en_q      <= 1'b0;
      last_q    <= 1'b0;
      lock_q    <= 1'b0;
      terr_q    <= 1'b0;
      data_q    <= '0;
      rr_ptr_q  <= 3'd1;
      timer_q   <= '0;
    end else begin
      en_q      <= 1'b0;
      ack_q     <= '0;
      ack_err_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HOLD: begin
          if (issue_go) begin
            gnt_q   <= issue_oh;
            data_q  <= sel_data;
            last_q  <= sel_last;
            en_q    <= 1'b1;
            timer_q <= '0;
            state_q <= S_ISSUE;
          end else if (state_q == S_HOLD && !hold_ok) begin
            gnt_q   <= '0;
            lock_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (bus.lcd_wr_done) begin
            ack_q   <= gnt_q;
            lock_q  <= ~last_q;
            state_q <= S_ACK;
          end else if (tmo_hit) begin
            ack_q     <= gnt_q;
            ack_err_q <= 1'b1;
            terr_q    <= 1'b1;
            lock_q    <= 1'b0;
            state_q   <= S_ACK;
          end else begin
            timer_q <= timer_inc;
          end
        end
        S_ACK: begin
          if (lock_q) begin
            state_q <= S_HOLD;
          end else begin
            gnt_q    <= '0;
            rr_ptr_q <= ptr_nxt;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.ack          = ack_q;
  assign bus.ack_err      = ack_err_q;
  assign bus.lcd_data     = data_q;
  assign bus.lcd_en_write = en_q;
  assign timeout_err_o    = terr_q;

endmodule

// File: tb/tb_lcd_write_arb.sv
// Scoreboard bench for lcd_write_arb: expected writes are queued with the stimulus and
// matched against every en_write and ack the arbiter produces.
module tb_lcd_write_arb;
  import lcd_write_arb_pkg::*;

  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done = 1'b0;
  logic timeout_err;

  lcd_write_arb_if #(.NREQ(NREQ)) bus ();

  lcd_write_arb #(.NREQ(NREQ), .TIMEOUT(16'd100)) dut (
    .clk           (clk),
    .rst           (rst),
    .init_done_i   (init_done),
    .timeout_err_o (timeout_err),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [8:0]      data;
    logic            err;
    int              lat;
    int              gap;
    int              at;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  bit         cur_valid = 0;
  logic [9:0] rq [NREQ][$];
  int n_chk = 0, n_pass = 0, cyc = 0, en_cyc = 0, last_en = -1000;
  int wr_count = 0, n_pushed = 0, ack_count = 0, cd = 0, wd_delay = 8;
  bit wr_auto = 1, suppress = 0, auto_wd = 0, man_wd = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_exp(input logic [NREQ-1:0] g, input logic [8:0] d, input logic err,
                          input int lat, input int gap, input int at);
    exp_t e;
    e.gnt = g; e.data = d; e.err = err; e.lat = lat; e.gap = gap; e.at = at;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic push_word(input int i, input logic last, input logic [8:0] d);
    rq[i].push_back({last, d});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || cur_valid) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, exp_q.size() + int'(cur_valid), 0);
    tick(2);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor, writer model and requester drivers, all evaluated on the falling edge.
  initial begin
    bus.req = '0; bus.req_last = '0; bus.req_data = '0; bus.lcd_wr_done = 1'b0;
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst) begin
        cur_valid = 0;
        cd = 0;
        auto_wd = 0;
      end else begin
        if (bus.lcd_en_write) begin
          wr_count++;
          if (exp_q.size() == 0) begin
            chk("wr_count", wr_count, n_pushed);
          end else begin
            e = exp_q.pop_front();
            chk("wr_gnt", bus.gnt, e.gnt);
            chk("wr_data", bus.lcd_data, e.data);
            if (e.gap >= 0) chk("wr_gap", cyc - last_en, e.gap);
            if (e.at >= 0) chk("wr_at", cyc, e.at);
            cur = e;
            cur_valid = 1;
            en_cyc = cyc;
          end
          last_en = cyc;
        end
        if (bus.ack != '0) begin
          if (!cur_valid) begin
            chk("unexp_ack", bus.ack, 0);
          end else begin
            chk("ack_vec", bus.ack, cur.gnt);
            chk("ack_err", bus.ack_err, cur.err);
            chk("ack_lat", cyc - en_cyc, cur.lat);
            cur_valid = 0;
          end
          ack_count++;
        end else if (bus.ack_err) begin
          chk("ack_err_alone", bus.ack_err, 0);
        end
        auto_wd = 0;
        if (cd > 0) begin
          cd--;
          if (cd == 0 && !suppress) auto_wd = 1;
        end
        if (bus.lcd_en_write) cd = wd_delay;
      end
      bus.lcd_wr_done = wr_auto ? auto_wd : man_wd;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        if (rq[i].size() != 0) begin
          bus.req[i]              = 1'b1;
          bus.req_last[i]         = rq[i][0][9];
          bus.req_data[i*9 +: 9]  = rq[i][0][8:0];
        end else begin
          bus.req[i]      = 1'b0;
          bus.req_last[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    int base;
    tick(3);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_en", bus.lcd_en_write, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_ack_err", bus.ack_err, 0);
    chk("rst_data", bus.lcd_data, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;
    tick(2);

    // Init gating: display sources wait until init_done.
    push_word(1, 1'b1, 9'h0A1); push_word(1, 1'b1, 9'h0A2);
    push_word(2, 1'b1, 9'h0B1); push_word(2, 1'b1, 9'h0B2);
    tick(50);
    chk("gate_gnt", bus.gnt, 0);
    chk("gate_wr", wr_count, 0);
    push_word(0, 1'b1, 9'h011);
    push_exp(3'b001, 9'h011, 1'b0, 9, -1, cyc + 1);
    wait_idle("drain_init");

    // Round robin 1,2,0,1,2,0 with 11-cycle spacing.
    push_word(0, 1'b1, 9'h0C1); push_word(0, 1'b1, 9'h0C2);
    push_exp(3'b010, 9'h0A1, 1'b0, 9, -1, -1);
    push_exp(3'b100, 9'h0B1, 1'b0, 9, 11, -1);
    push_exp(3'b001, 9'h0C1, 1'b0, 9, 11, -1);
    push_exp(3'b010, 9'h0A2, 1'b0, 9, 11, -1);
    push_exp(3'b100, 9'h0B2, 1'b0, 9, 11, -1);
    push_exp(3'b001, 9'h0C2, 1'b0, 9, 11, -1);
    init_done = 1'b1;
    wait_idle("drain_rr");

    // Locked three-word transaction from requester 1 before requester 2.
    push_word(1, 1'b0, 9'h02A); push_word(1, 1'b0, 9'h100); push_word(1, 1'b1, 9'h1EF);
    push_word(2, 1'b1, 9'h055);
    push_exp(3'b010, 9'h02A, 1'b0, 9, -1, -1);
    push_exp(3'b010, 9'h100, 1'b0, 9, 11, -1);
    push_exp(3'b010, 9'h1EF, 1'b0, 9, 11, -1);
    push_exp(3'b100, 9'h055, 1'b0, 9, 11, -1);
    wait_idle("drain_lock");

    // Watchdog abort after 100 WAIT cycles, then normal service resumes.
    chk("terr_pre", timeout_err, 0);
    suppress = 1;
    push_word(2, 1'b1, 9'h0C3);
    push_exp(3'b100, 9'h0C3, 1'b1, 101, -1, -1);
    wait_idle("drain_tmo");
    suppress = 0;
    chk("terr_set", timeout_err, 1);
    push_word(0, 1'b1, 9'h033); push_word(1, 1'b1, 9'h044);
    push_exp(3'b001, 9'h033, 1'b0, 9, -1, -1);
    push_exp(3'b010, 9'h044, 1'b0, 9, 11, -1);
    wait_idle("drain_resume");
    chk("terr_sticky", timeout_err, 1);

    // Reset during WAIT; afterwards requester 1 wins again from rr_ptr=1.
    push_word(1, 1'b1, 9'h0BB);
    push_exp(3'b010, 9'h0BB, 1'b0, 9, -1, cyc + 1);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick(1);
      n++;
    end
    chk("pre_rst_issue", exp_q.size(), 0);
    push_word(0, 1'b1, 9'h0AA);
    tick(3);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", bus.gnt, 0);
    chk("mid_rst_en", bus.lcd_en_write, 0);
    chk("mid_rst_ack", bus.ack, 0);
    chk("mid_rst_data", bus.lcd_data, 0);
    chk("mid_rst_terr", timeout_err, 0);
    push_exp(3'b010, 9'h0BB, 1'b0, 9, -1, -1);
    push_exp(3'b001, 9'h0AA, 1'b0, 9, 11, -1);
    tick(2);
    rst = 1'b0;
    wait_idle("drain_rst");

    // wr_done during ISSUE is ignored; the later one yields a single ack.
    wr_auto = 0;
    man_wd = 0;
    base = ack_count;
    push_word(2, 1'b1, 9'h0CC);
    push_exp(3'b100, 9'h0CC, 1'b0, 6, -1, cyc + 1);
    tick(1); man_wd = 1;
    tick(1); man_wd = 0;
    tick(4); man_wd = 1;
    tick(1); man_wd = 0;
    wait_idle("drain_stale");
    tick(10);
    chk("stale_acks", ack_count - base, 1);
    wr_auto = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/lcd_write_arb.md
Name: lcd_write_arb

Overview:
- Shares the single LCD SPI byte writer (9-bit {dc,byte} word, en_write pulse / wr_done pulse handshake) among NREQ requesters.
- Requester 0 is the init sequencer; the others are display sources (picture stream, text overlay, ...).
- Replaces the ad-hoc init/picture mux in the top-level controller.
- Provides:
  - round-robin arbitration;
  - transaction locking, so command+parameter sequences are not interleaved;
  - init gating;
  - a wr_done watchdog.

Parameters:
- NREQ, 3, number of requesters (2..8); index 0 is the init requester.
- DW, 9, word width: bit 8 = dc, bits 7:0 = SPI byte.
- TIMEOUT, 16'd4095, clk cycles allowed in WAIT before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- init_done  in  1  LCD init complete. Level; assumed monotonic after reset.
- req  in  NREQ  per-requester word valid. Held until the matching ack.
- req_last  in  NREQ  current word ends the requester's transaction.
- req_data  in  NREQ*DW  packed words; requester i occupies bits [i*DW +: DW].
- ack  out  NREQ  one-cycle pulse: word i consumed.
- ack_err  out  1  qualifies ack: word aborted by timeout.
- gnt  out  NREQ  one-hot current owner; zero when idle.
- lcd_data  out  DW  to writer data.
- lcd_en_write  out  1  to writer en_write. Single-cycle pulse.
- lcd_wr_done  in  1  from writer wr_done. Single-cycle pulse.
- timeout_err  out  1  sticky flag; cleared only by rst.

Behaviour:
- Reset (async, rst=1): all outputs are 0, state=IDLE, rr_ptr=1, lock=0, timer=0. Applies immediately mid-transfer; lcd_en_write drops with no pending ack.
- Eligibility:
  - While init_done=0, only req[0] is eligible.
  - After init_done=1, all requesters are eligible.
- States:
  - IDLE:
    - If any eligible req is set, pick the first set bit searching rr_ptr, rr_ptr+1, ... modulo NREQ.
    - Register gnt one-hot, set lcd_data=req_data[winner], pulse lcd_en_write, go to ISSUE.
    - No eligible req: stay.
  - ISSUE: lcd_en_write is high for exactly this cycle; go to WAIT.
    - A lcd_wr_done seen in the ISSUE cycle is ignored.
  - WAIT: lcd_data is held stable; the timer increments each cycle.
    - On lcd_wr_done: pulse ack[gnt] with ack_err=0; lock <= ~req_last[gnt] as sampled at issue; go to ACK.
    - If the timer reaches TIMEOUT first: pulse ack[gnt] with ack_err=1, set timeout_err, force lock=0, go to ACK.
  - ACK (1 cycle): req is not sampled, so a requester dropping req in reaction to ack is never re-issued.
    - If lock=1: go to HOLD.
    - Else: clear gnt, rr_ptr <= (owner+1) mod NREQ, go to IDLE.
  - HOLD: gnt is kept.
    - Only req[owner] is considered; on req[owner], issue as in IDLE (no arbitration).
    - Other requesters wait indefinitely.
    - If the owner is not eligible (init_done fell, illegal), behave as in IDLE.
- Latency:
  - req sampled in cycle n → lcd_en_write in cycle n+1.
  - lcd_wr_done in cycle k → ack in cycle k+1.
  - Earliest back-to-back en_write: k+3.
- Invariants:
  - At most one lcd_en_write is outstanding.
  - The ack and gnt vectors are one-hot or zero.
  - ack_err is 0 whenever ack is 0.
- The timer is 16 bits and saturates; it clears on every issue.

Decomposition:
- Shared package lcd_pkg:
  - DW;
  - dc bit index (8);
  - state encoding IDLE/ISSUE/WAIT/ACK/HOLD;
  - default TIMEOUT.
- One natural sub-module: rr_pick.
  - Combinational rotate-priority encoder.
  - Inputs: req vector and rr_ptr. Output: one-hot winner.
  - Parameterized by NREQ and reusable by other arbiters.

Test Plan:
- Init gating: init_done=0; req=3'b110; hold 50 cycles → no lcd_en_write and gnt=0. Set req[0]=1 with last=1 and data=9'h011 → lcd_en_write one cycle later with lcd_data=9'h011.
- Round robin: init_done=1; req=3'b111, all last=1; writer model returns wr_done 8 cycles after en_write → grant order 1,2,0,1,2,0. Each ack arrives 1 cycle after wr_done; the en_write spacing is exactly 11 cycles.
- Lock: req[1] sends 3 words 9'h02A, 9'h100, 9'h1EF with last=0,0,1 while req[2] is held high → three consecutive writes from requester 1, then requester 2.
- Timeout: TIMEOUT=100; wr_done suppressed → ack[gnt] and ack_err high in the same cycle, 101 cycles after en_write; timeout_err stays 1; arbitration resumes.
- Reset mid-op: assert rst during WAIT → all outputs 0 asynchronously. After release, the pending req is reissued with rr_ptr=1 priority.
- Stale wr_done: wr_done coincident with en_write (ISSUE cycle) → ignored. The real wr_done 5 cycles later produces exactly one ack.
